// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types, constants and address check for the data memory controller
package mem_ctrl_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int WORD_BYTES       = 4;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Word address as seen by the RAM: byte address with the byte offset dropped.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
    return {2'b00, addr[ADDR_W-1:2]};
  endfunction

  // Misaligned, or beyond the implemented depth; the full 30-bit word address
  // is compared so high address bits never alias onto real RAM words.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int depth_log2);
    logic [ADDR_W-1:0] word;
    word = word_addr(addr);
    return (addr[1:0] != 2'b00) || ((word >> depth_log2) != '0);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core-side request/response handshake bundle
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_err;

  // Core memory stage: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );

  // Controller: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store controller in front of the data block RAM
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  core,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Out-of-range parameter values are clamped so the 2-bit counter never wraps.
  localparam int LAT_CLAMP =
    (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
    (READ_LATENCY < 1)                ? 1 : READ_LATENCY;
  localparam logic [1:0] LAT_INIT = 2'(LAT_CLAMP - 1);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       lat_write;

  // Request FSM: RAM port and response registers are all updated here so every
  // output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_cnt        <= 2'd0;
      lat_write      <= 1'b0;
      core.req_ready <= 1'b1;
      core.rsp_valid <= 1'b0;
      core.rsp_rdata <= '0;
      core.rsp_write <= 1'b0;
      core.rsp_err   <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core.req_valid) begin
            lat_write      <= core.req_write;
            core.req_ready <= 1'b0;
            if (addr_err(core.req_addr, DEPTH_LOG2)) begin
              // Rejected request: answer immediately, RAM port untouched.
              core.rsp_valid <= 1'b1;
              core.rsp_err   <= 1'b1;
              core.rsp_write <= core.req_write;
              core.rsp_rdata <= '0;
              state          <= RESP;
            end else begin
              // Present the access to the RAM during ISSUE.
              mem_we    <= core.req_write;
              mem_addr  <= word_addr(core.req_addr);
              mem_wdata <= core.req_wdata;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          if (lat_write) begin
            core.rsp_valid <= 1'b1;
            core.rsp_err   <= 1'b0;
            core.rsp_write <= 1'b1;
            core.rsp_rdata <= '0;
            state          <= RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            core.rsp_valid <= 1'b1;
            core.rsp_err   <= 1'b0;
            core.rsp_write <= 1'b0;
            core.rsp_rdata <= mem_rdata;
            state          <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          // Response held until consumed; no same-cycle acceptance of the next request.
          if (core.rsp_ready) begin
            core.rsp_valid <= 1'b0;
            core.req_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the data memory port: accepts load/store requests from the core's memory stage over a valid/ready handshake, drives the block-RAM port (address, write data, write enable), waits out the RAM read latency, and returns the load data or store acknowledgement over a held response handshake. Sits between the core datapath and the main memory instance. One request is outstanding at a time, and the core stalls on `req_ready` low.

## Interface
- `READ_LATENCY`, default 1: RAM clock edges from address sample to valid `mem_rdata`; legal range 1..4.
- `DEPTH_LOG2`, default 10: number of word-address bits implemented by the RAM.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: response present; held until `rsp_ready` is high.
- `rsp_ready` in 1: core consumes the response.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_write` out 1: echoes `req_write` of the request being answered.
- `rsp_err` out 1: request was misaligned or out of range; no memory access performed.
- `mem_we` out 1: RAM write enable, one cycle per store. The RAM wrapper widens it to its byte-enable port.
- `mem_addr` out 32: word address to the RAM, equal to `req_addr >> 2`.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `req_write`, `req_addr`, `req_wdata`.
  - Error check: `req_addr[1:0] != 0`, or `req_addr[31:2] >= 2**DEPTH_LOG2`.
  - Error → RESP with `rsp_err` = 1; `mem_*` are not touched.
  - Otherwise → ISSUE.
- **ISSUE**
  - `mem_addr` and `mem_wdata` are registered, driven from the latched request.
  - `mem_we` = `req_write`.
  - Store → RESP. Load → WAIT, with the latency counter loaded to `READ_LATENCY`-1.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter is 0: capture `mem_rdata` into the `rsp_rdata` register → RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata`, `rsp_write` and `rsp_err` are stable.
  - On `rsp_ready` → IDLE.
  - No new request is accepted in the same cycle (no IDLE bypass).
- `mem_we` is 0 in every state except ISSUE for a store.
- `mem_addr` and `mem_wdata` hold their last values outside ISSUE.
- `req_ready` is 0 in ISSUE, WAIT and RESP. `req_*` inputs are ignored in those states.
- Counter width: 2 bits. It saturates at 0 and never wraps.

## Timing
- Reset values, all outputs: `req_ready` = 1; `rsp_valid`, `rsp_write`, `rsp_err`, `mem_we` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0. State = IDLE.
- Handshake accepted in cycle T (`req_valid` & `req_ready`):
  - Store: `mem_we` = 1 in T+1; `rsp_valid` from T+2.
  - Load: address on `mem_addr` in T+1; data captured at the end of T+1+`READ_LATENCY`; `rsp_valid` from T+2+`READ_LATENCY` (T+3 at default).
  - Error: `rsp_valid` from T+1.
- Back-to-back: earliest next acceptance is the cycle after the `rsp_ready` handshake. Store throughput is therefore one request per 3 cycles.
- `rsp_ready` held low: `rsp_valid` and the data stay constant indefinitely. No RAM activity.
- `rsp_ready` high before `rsp_valid`: has no effect until RESP.
- Reset mid-operation: `rst_n` low in any cycle → IDLE and reset values at that edge.
  - A store whose `mem_we` was already high in that cycle completes in the RAM.
  - The pending response is discarded.
- Address arithmetic: `mem_addr` = {2'b00, `req_addr[31:2]`}. The range check uses the full 30-bit word address, so there is no aliasing.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - `WORD_BYTES` = 4
  - `MAX_READ_LATENCY` = 4
  - `ADDR_W` = 32, `DATA_W` = 32
- The FSM, latency counter and response registers live in one module.
- No sub-module is required. The latency counter stays inline.

## Test plan
- Reset with `rst_n` low for 2 cycles → all outputs at reset values, `req_ready` = 1.
- Store to 0x0000_0010, data 0xDEAD_BEEF:
  - `mem_we` = 1, `mem_addr` = 0x4, `mem_wdata` = 0xDEADBEEF at T+1.
  - `rsp_valid` at T+2 with `rsp_write` = 1, `rsp_err` = 0.
- Load from 0x10 with a RAM model at `READ_LATENCY` = 1, then at 3:
  - `rsp_rdata` = 0xDEADBEEF at T+3 and T+5 respectively.
  - `mem_we` = 0 throughout.
- Error requests, load 0x0000_0013 and store 0x0001_0000 (`DEPTH_LOG2` = 10):
  - `rsp_err` = 1 at T+1.
  - No `mem_we` pulse; `mem_addr` unchanged.
- Backpressure and reset:
  - `rsp_ready` low for 5 cycles → response held stable, `req_ready` = 0.
  - Reset asserted in WAIT → IDLE next cycle, `rsp_valid` never rises.
